// File: rtl/sync_rom_reader.sv
// Read initiator for a 1-cycle synchronous ROM port: takes {addr, len} commands and
// streams the words out through a 2-entry buffer. Optional checksum port: SYNC_ROM_READER_CHKSUM_EN.
module sync_rom_reader #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [AWIDTH:0]   cmd_len,
  output logic              rom_en,
  output logic [AWIDTH-1:0] rom_addr,
  input  logic [DWIDTH-1:0] rom_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last,
  output logic              done,
`ifdef SYNC_ROM_READER_CHKSUM_EN
  output logic              busy,
  output logic [DWIDTH-1:0] chk
`else
  output logic              busy
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state, state_next;
  logic [AWIDTH-1:0] cur_addr;
  logic [AWIDTH:0]   rem;
  logic              inflight;
  logic              inflight_last;
  logic [DWIDTH-1:0] fifo_data [2];
  logic              fifo_last [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic [2:0]        occupancy;
  logic              accept, issue, push, pop;

  assign cmd_ready = (state == IDLE);
  assign busy      = !cmd_ready;
  assign accept    = cmd_valid && cmd_ready;

  assign out_valid = (count != 2'd0);
  assign out_data  = fifo_data[rd_ptr];
  assign out_last  = out_valid && fifo_last[rd_ptr];
  assign pop       = out_valid && out_ready;
  assign push      = inflight;

  // Words buffered plus the one on its way back from the ROM; a read may only be
  // issued if a slot is free now or one is being freed this cycle.
  assign occupancy = {1'b0, count} + {2'b00, inflight};
  assign issue     = (state == FETCH) && (rem != '0) && ((occupancy < 3'd2) || pop);
  assign rom_en    = issue;
  assign rom_addr  = cur_addr;

  // NOTE: every output of a combinational block is given a default first so no
  // path through the case statement leaves it unassigned (which would infer a latch).
  always_comb begin
    state_next = state;
    done       = 1'b0;
    unique case (state)
      IDLE:  if (cmd_valid) state_next = (cmd_len == '0) ? DRAIN : FETCH;
      FETCH: if (issue && (rem == (AWIDTH+1)'(1))) state_next = DRAIN;
      DRAIN: begin
        if (!inflight && (count == 2'd0)) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr      <= '0;
      rem           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      if (accept) begin
        cur_addr <= cmd_addr;
        rem      <= cmd_len;
      end else if (issue) begin
        cur_addr <= cur_addr + AWIDTH'(1);
        rem      <= rem - (AWIDTH+1)'(1);
      end
      inflight      <= issue;
      inflight_last <= issue && (rem == (AWIDTH+1)'(1));
    end
  end

  // NOTE: the two buffer entries are reset because the head drives out_data
  // directly and must read 0 after reset; a deep RAM would not be reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last[0] <= 1'b0;
      fifo_last[1] <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= rom_q;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef SYNC_ROM_READER_CHKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      chk <= '0;
    else if (accept) chk <= '0;
    else if (pop)    chk <= chk ^ out_data;
  end
`endif

endmodule

// File: tb/tb_sync_rom_reader.sv
// Scoreboard bench for sync_rom_reader: directed commands push expected words, a
// negedge monitor pops and compares every output handshake.
module tb_sync_rom_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_addr;
  logic [8:0] cmd_len;
  logic       rom_en;
  logic [7:0] rom_addr;
  logic [7:0] rom_q;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       done;
  logic       busy;
`ifdef SYNC_ROM_READER_CHKSUM_EN
  logic [7:0] chk;
`endif

  sync_rom_reader #(.DWIDTH(8), .AWIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_q(rom_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .done(done),
`ifdef SYNC_ROM_READER_CHKSUM_EN
    .busy(busy), .chk(chk)
`else
    .busy(busy)
`endif
  );

  always #5 clk = ~clk;

  // ROM model: mem[i] = i, one-cycle registered read gated by rom_en
  logic [7:0] rom_mem [256];
  initial begin
    rom_q = 8'h00;
    for (int i = 0; i < 256; i++) rom_mem[i] = i[7:0];
  end
  always @(posedge clk) if (rom_en) rom_q <= rom_mem[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [8:0] sb_q [$];
  int en_cyc_q [$];
  int en_addr_q [$];
  int ov_cyc_q [$];
  int hs_cyc = 0;
  int issued = 0;
  int popped = 0;
  int max_out = 0;
  int valid_seen = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [7:0] chk_at_done = 8'h00;
  logic       stall_prev = 1'b0;
  logic [8:0] held = 9'h000;

  // Monitor: samples mid-cycle, compares handshakes against the scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
      issued     = 0;
      popped     = 0;
    end else begin
      if (issued - popped > max_out) max_out = issued - popped;
      if (out_valid) valid_seen++;
      if (stall_prev && out_valid) check("hold", {23'd0, out_last, out_data}, {23'd0, held});
      stall_prev = out_valid && !out_ready;
      held       = {out_last, out_data};
      if (out_valid && out_ready) begin
        ov_cyc_q.push_back(cyc);
        if (sb_q.size() == 0) begin
          vectors++;
          fails++;
          $display("FAIL spurious_word: got %0h with nothing expected (cycle %0d)", out_data, cyc);
        end else begin
          logic [8:0] e;
          e = sb_q.pop_front();
          check("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
          check("out_last", {31'd0, out_last}, {31'd0, e[8]});
        end
        popped++;
      end
      if (rom_en) begin
        en_cyc_q.push_back(cyc);
        en_addr_q.push_back(int'(rom_addr));
        issued++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
`ifdef SYNC_ROM_READER_CHKSUM_EN
        chk_at_done = chk;
`endif
      end
    end
  end

  task automatic send_cmd(input logic [7:0] a, input logic [8:0] l);
    @(posedge clk); #1;
    for (int i = 0; i < 20 && !cmd_ready; i++) begin @(posedge clk); #1; end
    check("cmd_ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    hs_cyc    = cyc;
    en_cyc_q.delete();
    en_addr_q.delete();
    ov_cyc_q.delete();
    for (int i = 0; i < int'(l); i++) begin
      logic [7:0] w;
      w = a + i[7:0];
      sb_q.push_back({(i == int'(l) - 1), w});
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input logic [23:0] pat);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) begin
      @(posedge clk); #1;
      out_ready = pat[i % 24];
    end
    check("done_pulses", done_cnt - d0, 32'd1);
    out_ready = 1'b1;
    check("sb_empty", sb_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, "_busy"},      {31'd0, busy},      32'd0);
    check({tag, "_rom_en"},    {31'd0, rom_en},    32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_done"},      {31'd0, done},      32'd0);
    check({tag, "_out_data"},  {24'd0, out_data},  32'd0);
    check({tag, "_out_last"},  {31'd0, out_last},  32'd0);
    check({tag, "_rom_addr"},  {24'd0, rom_addr},  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int v0, p0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = 8'h00;
    cmd_len   = 9'd0;
    out_ready = 1'b1;
    #3;
    check_reset_outputs("reset");
    @(negedge clk); #1 rst_n = 1'b1;

    // Basic: addr 0x10, len 3, exact cycle timing
    send_cmd(8'h10, 9'd3);
    wait_done(40, 24'hFFFFFF);
    check("basic_en_count", en_cyc_q.size(), 32'd3);
    for (int i = 0; i < en_cyc_q.size(); i++) begin
      check("basic_en_cycle", en_cyc_q[i] - hs_cyc, i + 1);
      check("basic_en_addr", en_addr_q[i], 32'h10 + i);
    end
    check("basic_out_count", ov_cyc_q.size(), 32'd3);
    for (int i = 0; i < ov_cyc_q.size(); i++) check("basic_out_cycle", ov_cyc_q[i] - hs_cyc, i + 3);
    check("basic_done_cycle", done_cyc - hs_cyc, 32'd6);
`ifdef SYNC_ROM_READER_CHKSUM_EN
    check("basic_chk", {24'd0, chk_at_done}, 32'h13);
`endif

    // Address wrap: FE, FF, 00, 01
    send_cmd(8'hFE, 9'd4);
    wait_done(40, 24'hFFFFFF);
`ifdef SYNC_ROM_READER_CHKSUM_EN
    check("wrap_chk", {24'd0, chk_at_done}, 32'h00);
`endif

    // Backpressure with a 5-cycle stall in the ready pattern
    max_out = 0;
    send_cmd(8'h00, 9'd8);
    wait_done(200, 24'b1110_1101_0110_0000_1011_0011);
    check("bp_max_outstanding_le2", {31'd0, (max_out <= 2)}, 32'd1);
    check("bp_out_count", ov_cyc_q.size(), 32'd8);
`ifdef SYNC_ROM_READER_CHKSUM_EN
    check("bp_chk", {24'd0, chk_at_done}, 32'h00);
`endif

    // Zero-length command
    v0 = valid_seen;
    send_cmd(8'h55, 9'd0);
    wait_done(20, 24'hFFFFFF);
    check("len0_en_count", en_cyc_q.size(), 32'd0);
    check("len0_valid_seen", valid_seen - v0, 32'd0);
    check("len0_done_cycle", done_cyc - hs_cyc, 32'd1);

    // Reset mid-command after 3 words, with a read in flight
    send_cmd(8'h40, 9'd8);
    p0 = popped;
    for (int i = 0; i < 50 && popped - p0 < 3; i++) begin @(posedge clk); #1; end
    check("midrst_words_before", popped - p0, 32'd3);
    #1 rst_n = 1'b0;
    sb_q.delete();
    #1;
    check_reset_outputs("midrst");
    @(negedge clk); #1 rst_n = 1'b1;
    v0 = valid_seen;
    for (int i = 0; i < 6; i++) @(posedge clk);
    check("midrst_no_stale_valid", valid_seen - v0, 32'd0);
    send_cmd(8'h20, 9'd2);
    wait_done(40, 24'hFFFFFF);
    check("post_rst_out_count", ov_cyc_q.size(), 32'd2);
`ifdef SYNC_ROM_READER_CHKSUM_EN
    check("post_rst_chk", {24'd0, chk_at_done}, 32'h01);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
